uart_tx_buf: RTL and testbench



---
 rtl/uart_tx_buf.sv | 148 ++++++++++++++
 tb/tb_uart_tx_buf.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a DEPTH-entry byte FIFO feeding an 8N1 serializer.
// Back-to-back frames are sent with no idle gap while the FIFO holds data.
module uart_tx_buf #(
   parameter int BAUD  = 5207,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     send_start,
   input  logic [7:0]               send_data,
   output logic                     send_full,
   output logic                     send_busy,
   output logic                     send_finish,
   output logic                     send_overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     uart_dout
);

   localparam int CW = $clog2(BAUD);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD - 1);
   localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD - 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        r_state;
   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [CW-1:0] r_baudCnt;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;
   logic          r_dout;
   logic          r_finish;
   logic          r_overflow;

   logic w_full;
   logic w_push;
   logic w_bitEnd;
   logic w_pop;

   // Full comes from the registered level only, so a same-cycle pop never frees a slot.
   assign w_full   = (r_level == LW'(DEPTH));
   assign w_push   = send_start && !w_full && !rst;
   assign w_bitEnd = (r_baudCnt == BAUD_LAST);
   assign w_pop    = (r_level != '0) && ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= send_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_baudCnt  <= '0;
         r_bitIdx   <= '0;
         r_shift    <= '0;
         r_dout     <= 1'b1;
         r_finish   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr  <= r_rptr + PW'(1);
            r_shift <= r_mem[r_rptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         r_overflow <= send_start && w_full;
         // Raised one cycle early so the registered pulse lands on the last STOP cycle.
         r_finish   <= (r_state == STOP) && (r_baudCnt == BAUD_PRE);

         case (r_state)
            IDLE: begin
               r_dout    <= 1'b1;
               r_baudCnt <= '0;
               if (w_pop) begin
                  r_state <= START;
                  r_dout  <= 1'b0;
               end
            end
            START: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  r_bitIdx  <= '0;
                  r_dout    <= r_shift[0];
                  r_state   <= DATA;
               end else begin
                  r_baudCnt <= r_baudCnt + CW'(1);
               end
            end
            DATA: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  if (r_bitIdx == 3'd7) begin
                     r_state <= STOP;
                     r_dout  <= 1'b1;
                  end else begin
                     r_bitIdx <= r_bitIdx + 3'd1;
                     r_dout   <= r_shift[1];
                     r_shift  <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + CW'(1);
               end
            end
            STOP: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  if (w_pop) begin
                     r_state <= START;
                     r_dout  <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_dout  <= 1'b1;
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_dout  <= 1'b1;
            end
         endcase
      end
   end

   assign send_full     = w_full;
   assign send_busy     = (r_state != IDLE);
   assign send_finish   = r_finish;
   assign send_overflow = r_overflow;
   assign level         = r_level;
   assign uart_dout     = r_dout;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: constant vectors, directed frame sequences,
// and randomized traffic compared against a frame-schedule reference model.
module tb_uart_tx_buf;

   localparam int BAUD  = 4;
   localparam int DEPTH = 8;
   localparam int LBAUD = 5207;

   logic       clk;
   logic       rst;
   logic       send_start;
   logic [7:0] send_data;
   logic       send_full, send_busy, send_finish, send_overflow, uart_dout;
   logic [3:0] level;

   logic       rst2;
   logic       start2;
   logic [7:0] data2;
   logic       full2, busy2, finish2, ovf2, dout2;
   logic [3:0] level2;

   int nChecks = 0;
   int nErrors = 0;
   int cyc     = 0;

   int obsDout, obsBusy, obsFinish, obsLevel, obsFull, obsOvf;

   uart_tx_buf #(.BAUD(BAUD), .DEPTH(DEPTH)) uut (
      .clk(clk), .rst(rst), .send_start(send_start), .send_data(send_data),
      .send_full(send_full), .send_busy(send_busy), .send_finish(send_finish),
      .send_overflow(send_overflow), .level(level), .uart_dout(uart_dout)
   );

   uart_tx_buf #(.BAUD(LBAUD), .DEPTH(DEPTH)) uutLong (
      .clk(clk), .rst(rst2), .send_start(start2), .send_data(data2),
      .send_full(full2), .send_busy(busy2), .send_finish(finish2),
      .send_overflow(ovf2), .level(level2), .uart_dout(dout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each accepted byte becomes a scheduled frame. A frame starts two
   // cycles after its push, or right after the previous frame ends, whichever is later.
   typedef struct {
      int         push;
      int         start;
      logic [7:0] data;
   } frame_t;

   frame_t frames[$];
   int     lastEnd = -1;
   bit     rejPrev = 1'b0;

   function automatic int frameEnd(frame_t f);
      return f.start + 10 * BAUD - 1;
   endfunction

   function automatic int modelLevel(int t);
      int n = 0;
      foreach (frames[i]) if (frames[i].push < t && frames[i].start > t) n++;
      return n;
   endfunction

   function automatic int modelDout(int t);
      foreach (frames[i]) begin
         if (frames[i].start <= t && t <= frameEnd(frames[i])) begin
            int slot = (t - frames[i].start) / BAUD;
            logic [7:0] d = frames[i].data;
            if (slot == 0) return 0;
            if (slot == 9) return 1;
            return int'(d[slot-1]);
         end
      end
      return 1;
   endfunction

   function automatic int modelBusy(int t);
      foreach (frames[i]) if (frames[i].start <= t && t <= frameEnd(frames[i])) return 1;
      return 0;
   endfunction

   function automatic int modelFinish(int t);
      foreach (frames[i]) if (frameEnd(frames[i]) == t) return 1;
      return 0;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nErrors++;
         $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // One cycle: sample and model-check the outputs, drive this cycle's inputs, advance the model.
   task automatic applyStimulus(input bit pushIn, input logic [7:0] dataIn, input bit rstIn);
      @(negedge clk);
      obsDout   = int'(uart_dout);
      obsBusy   = int'(send_busy);
      obsFinish = int'(send_finish);
      obsLevel  = int'(level);
      obsFull   = int'(send_full);
      obsOvf    = int'(send_overflow);
      checkOutput("model.dout", obsDout, modelDout(cyc));
      checkOutput("model.busy", obsBusy, modelBusy(cyc));
      checkOutput("model.finish", obsFinish, modelFinish(cyc));
      checkOutput("model.level", obsLevel, modelLevel(cyc));
      checkOutput("model.full", obsFull, int'(modelLevel(cyc) == DEPTH));
      checkOutput("model.overflow", obsOvf, int'(rejPrev));
      rst        = rstIn;
      send_start = pushIn;
      send_data  = dataIn;
      if (rstIn) begin
         frames.delete();
         lastEnd = cyc;
         rejPrev = 1'b0;
      end else begin
         rejPrev = 1'b0;
         if (pushIn) begin
            if (modelLevel(cyc) < DEPTH) begin
               frame_t f;
               f.push  = cyc;
               f.start = (cyc + 2 > lastEnd + 1) ? cyc + 2 : lastEnd + 1;
               f.data  = dataIn;
               lastEnd = frameEnd(f);
               frames.push_back(f);
            end else begin
               rejPrev = 1'b1;
            end
         end
         while (frames.size() > 0 && frameEnd(frames[0]) < cyc) void'(frames.pop_front());
      end
      cyc++;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
   endtask

   // Single byte from idle: cycle 0 is the push cycle.
   task automatic sendOne(input logic [7:0] b);
      int firstLow = -1, lowCnt = 0, stopHi = 0, busyCnt = 0, firstBusy = -1;
      int finCnt = 0, finAt = -1;
      logic [7:0] rx = 8'h00;
      for (int t = 0; t < 46; t++) begin
         applyStimulus(t == 0, b, 1'b0);
         if (obsDout == 0 && firstLow < 0) firstLow = t;
         if (t < 6 && obsDout == 0) lowCnt++;
         if (t >= 6 && t < 38 && (t - 6) % 4 == 2) rx[(t-6)/4] = obsDout[0];
         if (t >= 38 && t < 42 && obsDout == 1) stopHi++;
         if (obsBusy == 1) begin
            busyCnt++;
            if (firstBusy < 0) firstBusy = t;
         end
         if (obsFinish == 1) begin
            finCnt++;
            finAt = t;
         end
      end
      checkOutput("one.firstLow", firstLow, 2);
      checkOutput("one.startLen", lowCnt, 4);
      checkOutput("one.dataBits", int'(rx), int'(b));
      checkOutput("one.stopLen", stopHi, 4);
      checkOutput("one.busyLen", busyCnt, 40);
      checkOutput("one.busyFirst", firstBusy, 2);
      checkOutput("one.finishCnt", finCnt, 1);
      checkOutput("one.finishAt", finAt, 41);
   endtask

   typedef struct {
      bit         push;
      logic [7:0] data;
      int         lvl;
      bit         full;
      bit         ovf;
      bit         busy;
      bit         dout;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] burst[3];
      int         finCyc[$];
      int         busyCnt;
      int         finCnt;

      vecs[0]  = '{1'b1, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 8'h21, 1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 8'h22, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 8'h23, 2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 8'h24, 3, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'h25, 4, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h26, 5, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'h27, 6, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 8'h28, 7, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 8'h29, 8, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 8, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b1, 1'b1};

      rst        = 1'b1;
      send_start = 1'b0;
      send_data  = 8'h00;
      rst2       = 1'b1;
      start2     = 1'b0;
      data2      = 8'h00;
      repeat (2) @(negedge clk);

      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("reset.dout", obsDout, 1);
      checkOutput("reset.busy", obsBusy, 0);
      checkOutput("reset.level", obsLevel, 0);
      checkOutput("reset.full", obsFull, 0);
      checkOutput("reset.finish", obsFinish, 0);
      checkOutput("reset.overflow", obsOvf, 0);
      idleCycles(3);

      sendOne(8'hA5);
      idleCycles(5);

      burst[0] = 8'h00;
      burst[1] = 8'hFF;
      burst[2] = 8'h3C;
      busyCnt  = 0;
      for (int t = 0; t < 130; t++) begin
         applyStimulus(t < 3, burst[t % 3], 1'b0);
         if (obsBusy == 1) busyCnt++;
         if (obsFinish == 1) finCyc.push_back(t);
      end
      checkOutput("burst.busyLen", busyCnt, 120);
      checkOutput("burst.finishCnt", finCyc.size(), 3);
      for (int i = 0; i < 3; i++)
         checkOutput("burst.finishAt", (i < finCyc.size()) ? finCyc[i] : -1, 41 + 40 * i);
      checkOutput("burst.levelEnd", obsLevel, 0);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].push, vecs[i].data, 1'b0);
         checkOutput("vec.level", obsLevel, vecs[i].lvl);
         checkOutput("vec.full", obsFull, int'(vecs[i].full));
         checkOutput("vec.overflow", obsOvf, int'(vecs[i].ovf));
         checkOutput("vec.busy", obsBusy, int'(vecs[i].busy));
         checkOutput("vec.dout", obsDout, int'(vecs[i].dout));
      end
      idleCycles(400);

      finCnt = 0;
      for (int t = 0; t < 60; t++) begin
         applyStimulus(t < 2, (t == 0) ? 8'h33 : 8'hCC, t == 20);
         if (obsFinish == 1) finCnt++;
         if (t == 21) begin
            checkOutput("abort.dout", obsDout, 1);
            checkOutput("abort.busy", obsBusy, 0);
            checkOutput("abort.level", obsLevel, 0);
         end
      end
      checkOutput("abort.finishCnt", finCnt, 0);
      sendOne(8'h81);

      for (int i = 0; i < 2500; i++) begin
         int pct = (i < 1250) ? 4 : 35;
         applyStimulus($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 599) == 0);
      end
      idleCycles(400);

      begin
         int edges[$];
         int prev = 1, lbusy = 0, lfin = 0, lfinAt = -1;
         @(negedge clk);
         rst2   = 1'b0;
         start2 = 1'b1;
         data2  = 8'h55;
         for (int t = 1; t < 52100; t++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (int'(dout2) != prev) edges.push_back(t);
            prev = int'(dout2);
            if (busy2) lbusy++;
            if (finish2) begin
               lfin++;
               lfinAt = t;
            end
         end
         checkOutput("long.edgeCnt", edges.size(), 10);
         checkOutput("long.firstEdge", (edges.size() > 0) ? edges[0] : -1, 2);
         for (int i = 1; i < 10; i++)
            checkOutput("long.bitLen", (i < edges.size()) ? edges[i] - edges[i-1] : -1, LBAUD);
         checkOutput("long.frameLen", lbusy, 10 * LBAUD);
         checkOutput("long.finishCnt", lfin, 1);
         checkOutput("long.finishAt", lfinAt, 1 + 10 * LBAUD);
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
